// File: rtl/sdram_probe_clear_if.sv
// ---------------------------------------------------------------------------
// sdram_probe_clear_if
//   Single-port command bus between the probe/clear sequencer and the SDRAM
//   controller.
//   master : sequencer side (drives address, write data and strobes)
//   slave  : controller side (drives ready and read data)
//   sdram_addr  [26:0] word address
//   sdram_din   [15:0] write data
//   sdram_rd           one-cycle read strobe
//   sdram_we           one-cycle write strobe
//   sdram_ready        controller idle, may accept a command
//   sdram_dout  [15:0] read data, valid when ready re-asserts after a read
// ---------------------------------------------------------------------------
interface sdram_probe_clear_if;
    logic [26:0] sdram_addr;
    logic [15:0] sdram_din;
    logic        sdram_rd;
    logic        sdram_we;
    logic        sdram_ready;
    logic [15:0] sdram_dout;

    modport master (
        output sdram_addr,
        output sdram_din,
        output sdram_rd,
        output sdram_we,
        input  sdram_ready,
        input  sdram_dout
    );

    modport slave (
        input  sdram_addr,
        input  sdram_din,
        input  sdram_rd,
        input  sdram_we,
        output sdram_ready,
        output sdram_dout
    );
endinterface

// File: rtl/sdram_probe_clear.sv
// ---------------------------------------------------------------------------
// sdram_probe_clear
//   Owns the SDRAM controller command port after PLL lock. Writes aliasing
//   signatures to probe the fitted memory size, publishes the result on cfg,
//   then zero-fills the first CLEAR_WORDS words so later cores see clean RAM.
//   Optional read-back sampling of the cleared area is enabled by defining
//   the macro SDRAM_CLEAR_VERIFY_EN.
//
// Ports
//   clk_sys     in   system clock, rising edge
//   reset       in   asynchronous, active-high
//   init        in   high while PLL unlocked; holds the sequencer idle
//   sdram       if   command bus (master modport)
//   cfg         out  [2]/[1]/[0] signature at 'h4000000/'h2000000/0 ok,
//                    [15] probe done
//   clear_done  out  zero-fill (and verify) finished
//   err_cnt     out  verify mismatches, saturating; 0 without verify
//
// Every command follows the same rhythm: issue on a cycle where ready is
// high (strobe registered, high one cycle), then one WAIT cycle in which
// ready is ignored, then wait for ready again.
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_RDY   | idle until init low and controller ready; cfg cleared
// W3         | write 3128 to 'h4000000
// W2         | write 2064 to 'h2000000
// W0         | write 1032 to 'h0000000
// W1         | write 12345 to 'h1000000
// R3         | read 'h4000000, cfg[2] = (dout == 3128)
// R2         | read 'h2000000, cfg[1] = (dout == 2064)
// R0         | read 'h0000000, cfg[0] = (dout == 1032), cfg[15] = 1
// CLEAR      | zero-fill 0..CLEAR_WORDS-1, at most one write per WR_GAP
// VERIFY     | read every VFY_STRIDE-th word, count non-zero (optional)
// DONE       | terminal, strobes idle, clear_done high
// ---------------------------------------------------------------------------
module sdram_probe_clear #(
    parameter int CLEAR_WORDS = 2**25,
    parameter int WR_GAP      = 32,
    parameter int VFY_STRIDE  = 4096
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       init,
    sdram_probe_clear_if.master        sdram,
    output logic [15:0]                cfg,
    output logic                       clear_done,
    output logic [15:0]                err_cnt
);

    localparam int              GW       = $clog2(WR_GAP) + 1;
    localparam logic [GW-1:0]   GAP_TC   = GW'(WR_GAP - 1);
    localparam logic [26:0]     CLR_LAST = 27'(CLEAR_WORDS - 1);

    localparam logic [26:0] A_SIG3 = 27'h4000000;
    localparam logic [26:0] A_SIG2 = 27'h2000000;
    localparam logic [26:0] A_SIG0 = 27'h0000000;
    localparam logic [26:0] A_SIG1 = 27'h1000000;
    localparam logic [15:0] D_SIG3 = 16'd3128;
    localparam logic [15:0] D_SIG2 = 16'd2064;
    localparam logic [15:0] D_SIG0 = 16'd1032;
    localparam logic [15:0] D_SIG1 = 16'd12345;

    typedef enum logic [3:0] {
        S_WAIT_RDY,
        S_W3,
        S_W2,
        S_W0,
        S_W1,
        S_R3,
        S_R2,
        S_R0,
        S_CLEAR,
`ifdef SDRAM_CLEAR_VERIFY_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    // Sub-phase of the command currently owned by the state.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_STROBE,
        PH_WAIT,
        PH_DATA
    } phase_t;

    state_t         state;
    phase_t         ph;
    logic [26:0]    addr_q;
    logic [15:0]    din_q;
    logic           rd_q;
    logic           we_q;
    logic [26:0]    clr_addr;
    logic [GW-1:0]  gap_cnt;
    logic           rdy;
    logic [15:0]    dout;

    assign rdy  = sdram.sdram_ready;
    assign dout = sdram.sdram_dout;

    assign sdram.sdram_addr = addr_q;
    assign sdram.sdram_din  = din_q;
    assign sdram.sdram_rd   = rd_q;
    assign sdram.sdram_we   = we_q;

    function automatic logic [26:0] probe_addr(input state_t s);
        case (s)
            S_W3, S_R3: probe_addr = A_SIG3;
            S_W2, S_R2: probe_addr = A_SIG2;
            S_W1:       probe_addr = A_SIG1;
            default:    probe_addr = A_SIG0;
        endcase
    endfunction

    function automatic logic [15:0] probe_data(input state_t s);
        case (s)
            S_W3:    probe_data = D_SIG3;
            S_W2:    probe_data = D_SIG2;
            S_W1:    probe_data = D_SIG1;
            default: probe_data = D_SIG0;
        endcase
    endfunction

    function automatic state_t probe_next(input state_t s);
        case (s)
            S_W3:    probe_next = S_W2;
            S_W2:    probe_next = S_W0;
            S_W0:    probe_next = S_W1;
            S_W1:    probe_next = S_R3;
            S_R3:    probe_next = S_R2;
            S_R2:    probe_next = S_R0;
            default: probe_next = S_CLEAR;
        endcase
    endfunction

`ifdef SDRAM_CLEAR_VERIFY_EN
    logic [26:0] vfy_addr;
    logic [31:0] vfy_next;
    logic [15:0] err_q;

    // Computed wide so a large stride cannot wrap back below CLEAR_WORDS.
    assign vfy_next = {5'd0, vfy_addr} + 32'(VFY_STRIDE);
    assign err_cnt  = err_q;
`else
    assign err_cnt  = 16'h0000;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_WAIT_RDY;
            ph         <= PH_ISSUE;
            addr_q     <= '0;
            din_q      <= '0;
            rd_q       <= 1'b0;
            we_q       <= 1'b0;
            cfg        <= '0;
            clear_done <= 1'b0;
            clr_addr   <= '0;
            gap_cnt    <= '0;
`ifdef SDRAM_CLEAR_VERIFY_EN
            vfy_addr   <= '0;
            err_q      <= '0;
`endif
        end else begin
            rd_q <= 1'b0;
            we_q <= 1'b0;

            case (state)
                S_WAIT_RDY: begin
                    cfg <= '0;
                    ph  <= PH_ISSUE;
                    if (!init && rdy) begin
                        state <= S_W3;
                    end
                end

                S_W3, S_W2, S_W0, S_W1: begin
                    case (ph)
                        PH_ISSUE: begin
                            if (rdy) begin
                                addr_q <= probe_addr(state);
                                din_q  <= probe_data(state);
                                we_q   <= 1'b1;
                                ph     <= PH_STROBE;
                            end
                        end
                        PH_STROBE: ph <= PH_WAIT;
                        default: begin
                            ph    <= PH_ISSUE;
                            state <= probe_next(state);
                        end
                    endcase
                end

                S_R3, S_R2, S_R0: begin
                    case (ph)
                        PH_ISSUE: begin
                            if (rdy) begin
                                addr_q <= probe_addr(state);
                                rd_q   <= 1'b1;
                                ph     <= PH_STROBE;
                            end
                        end
                        PH_STROBE: ph <= PH_WAIT;
                        PH_WAIT:   ph <= PH_DATA;
                        default: begin
                            // read data is valid on the first ready after WAIT
                            if (rdy) begin
                                ph <= PH_ISSUE;
                                case (state)
                                    S_R3: cfg[2] <= (dout == D_SIG3);
                                    S_R2: cfg[1] <= (dout == D_SIG2);
                                    default: begin
                                        cfg[0]  <= (dout == D_SIG0);
                                        cfg[15] <= 1'b1;
                                    end
                                endcase
                                if (state == S_R0) begin
                                    state    <= S_CLEAR;
                                    // first clear write may go on the next ready
                                    gap_cnt  <= GAP_TC;
                                    clr_addr <= '0;
                                end else begin
                                    state <= probe_next(state);
                                end
                            end
                        end
                    endcase
                end

                S_CLEAR: begin
                    if (gap_cnt < GAP_TC) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                    case (ph)
                        PH_ISSUE: begin
                            // gap holds at terminal count, so a late ready
                            // issues exactly once on its first high cycle
                            if (gap_cnt >= GAP_TC && rdy) begin
                                addr_q  <= clr_addr;
                                din_q   <= '0;
                                we_q    <= 1'b1;
                                gap_cnt <= '0;
                                ph      <= PH_STROBE;
                                if (clr_addr != CLR_LAST) begin
                                    clr_addr <= clr_addr + 27'd1;
                                end
                            end
                        end
                        PH_STROBE: ph <= PH_WAIT;
                        default: begin
                            ph <= PH_ISSUE;
                            // addr_q still holds the write just issued
                            if (addr_q == CLR_LAST) begin
`ifdef SDRAM_CLEAR_VERIFY_EN
                                state    <= S_VERIFY;
                                vfy_addr <= '0;
`else
                                state      <= S_DONE;
                                clear_done <= 1'b1;
`endif
                            end
                        end
                    endcase
                end

`ifdef SDRAM_CLEAR_VERIFY_EN
                S_VERIFY: begin
                    case (ph)
                        PH_ISSUE: begin
                            if (rdy) begin
                                addr_q <= vfy_addr;
                                rd_q   <= 1'b1;
                                ph     <= PH_STROBE;
                            end
                        end
                        PH_STROBE: ph <= PH_WAIT;
                        PH_WAIT:   ph <= PH_DATA;
                        default: begin
                            if (rdy) begin
                                ph <= PH_ISSUE;
                                if (dout != 16'h0000 && err_q != 16'hFFFF) begin
                                    err_q <= err_q + 16'd1;
                                end
                                if (vfy_next >= 32'(CLEAR_WORDS)) begin
                                    state      <= S_DONE;
                                    clear_done <= 1'b1;
                                end else begin
                                    vfy_addr <= vfy_next[26:0];
                                end
                            end
                        end
                    endcase
                end
`endif

                S_DONE: begin
                    clear_done <= 1'b1;
                end

                default: begin
                    state <= S_WAIT_RDY;
                    ph    <= PH_ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_probe_clear.sv
module tb_sdram_probe_clear;

    localparam int CW = 64;
    localparam int WG = 4;
    localparam int VS = 8;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        init    = 1'b1;
    logic [15:0] cfg;
    logic        clear_done;
    logic [15:0] err_cnt;

    sdram_probe_clear_if bus();

    sdram_probe_clear #(
        .CLEAR_WORDS (CW),
        .WR_GAP      (WG),
        .VFY_STRIDE  (VS)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .init       (init),
        .sdram      (bus),
        .cfg        (cfg),
        .clear_done (clear_done),
        .err_cnt    (err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [26:0] addr;
        logic [15:0] din;
        int          cyc;
    } cmd_t;

    cmd_t       log_q[$];
    cmd_t       exp_q[$];
    logic [15:0] mem[int];
    int  mask_m   = 32'h7FFFFFF;
    int  rdy_mode = 0;
    bit  corrupt  = 1'b0;
    int  cyc      = 0;
    int  since    = 1000;
    bit  hist1    = 1'b0;
    bit  hist2    = 1'b0;
    int  rel_cyc  = 0;

    // Controller + memory model: aliasing via address mask, ready policy per
    // mode, command-rule checks on every strobe.
    always @(negedge clk_sys) begin
        int   k;
        cmd_t c;
        cyc++;
        if (reset) begin
            log_q.delete();
            hist1 = 1'b0;
            hist2 = 1'b0;
            since = 1000;
            bus.sdram_ready = 1'b1;
            bus.sdram_dout  = 16'h0000;
        end else begin
            if (bus.sdram_we || bus.sdram_rd) begin
                chk("issue_rdy", bus.sdram_ready, 1);
                chk("cmd_wait", {hist1, hist2}, 0);
                chk("one_strobe", bus.sdram_we & bus.sdram_rd, 0);
                chk("strobe_after_done", clear_done, 0);
                c.we   = bus.sdram_we;
                c.addr = bus.sdram_addr;
                c.din  = bus.sdram_din;
                c.cyc  = cyc;
                log_q.push_back(c);
                k = int'(bus.sdram_addr) & mask_m;
                if (bus.sdram_we) begin
                    mem[k] = bus.sdram_din;
                end else if (corrupt && k == 8) begin
                    bus.sdram_dout = 16'h0001;
                end else begin
                    bus.sdram_dout = mem.exists(k) ? mem[k] : 16'h0000;
                end
            end
            if (bus.sdram_we && log_q.size() >= 8) since = 0;
            else if (since < 1000) since++;
            hist2 = hist1;
            hist1 = bus.sdram_we | bus.sdram_rd;
            case (rdy_mode)
                1:       bus.sdram_ready = ($urandom_range(0, 99) < 70);
                2:       bus.sdram_ready = !(since >= WG - 1 && since <= WG + 8);
                default: bus.sdram_ready = 1'b1;
            endcase
        end
    end

    function automatic logic [15:0] model_cfg(input int mask);
        logic [15:0] m[int];
        logic [15:0] r;
        r = '0;
        m[32'h4000000 & mask] = 16'd3128;
        m[32'h2000000 & mask] = 16'd2064;
        m[0]                  = 16'd1032;
        m[32'h1000000 & mask] = 16'd12345;
        r[2]  = (m[32'h4000000 & mask] == 16'd3128);
        r[1]  = (m[32'h2000000 & mask] == 16'd2064);
        r[0]  = (m[0] == 16'd1032);
        r[15] = 1'b1;
        return r;
    endfunction

    task automatic build_exp();
        logic [26:0] pa [7];
        logic [15:0] pd [4];
        cmd_t c;
        pa = '{27'h4000000, 27'h2000000, 27'h0, 27'h1000000,
               27'h4000000, 27'h2000000, 27'h0};
        pd = '{16'd3128, 16'd2064, 16'd1032, 16'd12345};
        exp_q.delete();
        c.cyc = 0;
        for (int i = 0; i < 7; i++) begin
            c.we = (i < 4); c.addr = pa[i]; c.din = (i < 4) ? pd[i] : 16'h0;
            exp_q.push_back(c);
        end
        for (int a = 0; a < CW; a++) begin
            c.we = 1'b1; c.addr = 27'(a); c.din = 16'h0;
            exp_q.push_back(c);
        end
`ifdef SDRAM_CLEAR_VERIFY_EN
        for (int a = 0; a < CW; a += VS) begin
            c.we = 1'b0; c.addr = 27'(a); c.din = 16'h0;
            exp_q.push_back(c);
        end
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"}, bus.sdram_addr, 0);
        chk({tag, "_din"}, bus.sdram_din, 0);
        chk({tag, "_rd"}, bus.sdram_rd, 0);
        chk({tag, "_we"}, bus.sdram_we, 0);
        chk({tag, "_cfg"}, cfg, 0);
        chk({tag, "_done"}, clear_done, 0);
        chk({tag, "_err"}, err_cnt, 0);
    endtask

    task automatic start_run(input int mask, input int mode, input int init_cyc,
                             input bit corr, input string tag);
        @(posedge clk_sys); #1;
        reset    = 1'b1;
        init     = (init_cyc > 0);
        mask_m   = mask;
        rdy_mode = mode;
        corrupt  = corr;
        mem.delete();
        repeat (3) @(negedge clk_sys);
        #1;
        check_reset_vals({tag, "_rst"});
        @(posedge clk_sys); #1;
        reset   = 1'b0;
        rel_cyc = cyc;
        if (init_cyc > 0) begin
            repeat (init_cyc) @(posedge clk_sys);
            #1;
            chk({tag, "_init_hold"}, log_q.size(), 0);
            init    = 1'b0;
            rel_cyc = cyc;
        end
    endtask

    task automatic finish_run(input string tag, input bit has_tbl, input logic [15:0] tbl_cfg);
        int n = 0;
        int nmis = 0;
        int nviol = 0;
        int d;
        int exp_err = 0;
        logic [26:0] exp_last;
        while (!clear_done && n < 8000) begin
            @(negedge clk_sys); #1;
            n++;
        end
        chk({tag, "_done_timeout"}, clear_done, 1);
        repeat (10) @(negedge clk_sys);
        #1;
        if (has_tbl) chk({tag, "_cfg_tbl"}, cfg, tbl_cfg);
        chk({tag, "_cfg_model"}, cfg, model_cfg(mask_m));
        build_exp();
        chk({tag, "_cmd_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && log_q[i].din !== exp_q[i].din)) begin
                if (nmis == 0)
                    $display("  first diff at cmd %0d: we=%0b addr=%0h din=%0h",
                             i, log_q[i].we, log_q[i].addr, log_q[i].din);
                nmis++;
            end
        end
        chk({tag, "_cmd_seq"}, nmis, 0);
        for (int i = 8; i < 7 + CW && i < log_q.size(); i++) begin
            d = log_q[i].cyc - log_q[i-1].cyc;
            if (rdy_mode == 0 && d != WG) nviol++;
            if (rdy_mode == 2 && d != WG + 10) nviol++;
            if (rdy_mode == 1 && d < WG) nviol++;
        end
        chk({tag, "_clr_spacing"}, nviol, 0);
        if (rdy_mode == 0 && log_q.size() > 0)
            chk({tag, "_first_cmd_lat"}, log_q[0].cyc, rel_cyc + 3);
`ifdef SDRAM_CLEAR_VERIFY_EN
        for (int a = 0; a < CW; a += VS)
            if (corrupt && (a & mask_m) == 8) exp_err++;
        exp_last = 27'(((CW - 1) / VS) * VS);
`else
        exp_last = 27'(CW - 1);
`endif
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_addr_hold"}, bus.sdram_addr, exp_last);
        chk({tag, "_idle"}, bus.sdram_we | bus.sdram_rd, 0);
    endtask

    typedef struct {
        int          mask;
        int          mode;
        int          init_cyc;
        bit          corr;
        logic [15:0] cfg_exp;
    } vec_t;

    initial begin
        vec_t vt[6];
        int   masks[4];
        int   n;
        vt[0] = '{32'h3FFFFFF, 0, 0,   1'b0, 16'h8003};
        vt[1] = '{32'h7FFFFFF, 0, 0,   1'b0, 16'h8007};
        vt[2] = '{32'h7FFFFFF, 2, 0,   1'b0, 16'h8007};
        vt[3] = '{32'h7FFFFFF, 0, 100, 1'b0, 16'h8007};
        vt[4] = '{32'h1FFFFFF, 1, 0,   1'b1, 16'h8001};
        vt[5] = '{32'h0FFFFFF, 1, 5,   1'b1, 16'h8000};
        masks = '{32'h3FFFFFF, 32'h7FFFFFF, 32'h1FFFFFF, 32'h0FFFFFF};

        for (int i = 0; i < 6; i++) begin
            start_run(vt[i].mask, vt[i].mode, vt[i].init_cyc, vt[i].corr, $sformatf("v%0d", i));
            finish_run($sformatf("v%0d", i), 1'b1, vt[i].cfg_exp);
        end

        // reset in the middle of the zero-fill, while the addr-20 strobe is high
        start_run(32'h7FFFFFF, 0, 0, 1'b0, "mid");
        n = 0;
        while (!(log_q.size() >= 8 && log_q[$].we && log_q[$].addr == 27'd20) && n < 3000) begin
            @(negedge clk_sys); #1;
            n++;
        end
        chk("mid_reach_addr20", n < 3000, 1);
        #1 reset = 1'b1;
        #1 check_reset_vals("mid_async");
        repeat (2) @(posedge clk_sys);
        #1;
        reset   = 1'b0;
        rel_cyc = cyc;
        finish_run("mid_restart", 1'b1, 16'h8007);

        for (int r = 0; r < 4; r++) begin
            start_run(masks[$urandom_range(0, 3)], 1, $urandom_range(0, 20),
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
            finish_run($sformatf("rnd%0d", r), 1'b0, 16'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
